// File: rtl/mem_hexdump_if.sv
// mem_hexdump_if
// Bundles every non-clock signal of mem_hexdump: the dump request
// (start/start_addr/end_addr), the memory read port (rd_en/rd_addr/rd_data),
// the ASCII byte stream (out_valid/out_data/out_ready) and status (busy/done).
//   master : the hexdump engine side (drives read port, byte stream, status)
//   slave  : the environment side (requests dumps, supplies memory data,
//            sinks the byte stream)
interface mem_hexdump_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, start_addr, end_addr, rd_data, out_ready,
    output rd_en, rd_addr, out_valid, out_data, busy, done
  );

  modport slave (
    output start, start_addr, end_addr, rd_data, out_ready,
    input  rd_en, rd_addr, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/mem_hexdump.sv
// mem_hexdump
// Walks a memory range (ascending or descending, both endpoints included)
// and streams each word as hex-memory-file compatible text: DATA_W/4 lowercase
// hex characters, most significant nibble first, followed by a newline.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mem_hexdump_if.master (request, memory read port, byte stream,
//          busy/done status)
// DATA_W must be a multiple of 4.
module mem_hexdump #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_hexdump_if.master bus
);
  localparam int NCHR  = DATA_W / 4;
  localparam int CNT_W = (NCHR > 1) ? $clog2(NCHR) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NCHR - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, EOL, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] end_q;
  logic              desc;
  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] shift_next;
  logic [ADDR_W-1:0] next_addr;

  // Next nibble is read from the already-shifted word so the byte presented
  // after a handshake is ready in the same edge.
  assign shift_next = shift << 4;
  // Modulo stepping; a legal dump stops at end_q before any wrap.
  assign next_addr  = desc ? addr - 1'b1 : addr + 1'b1;

  function automatic logic [7:0] to_hex(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
  endfunction

  // Single FSM with registered outputs; every output is updated together
  // with the transition that makes it change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      end_q         <= '0;
      desc          <= 1'b0;
      shift         <= '0;
      count         <= '0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'h00;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr        <= bus.start_addr;
            end_q       <= bus.end_addr;
            desc        <= (bus.start_addr > bus.end_addr);
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= bus.start_addr;
            bus.busy    <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          bus.rd_en <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          shift         <= bus.rd_data;
          count         <= '0;
          bus.out_valid <= 1'b1;
          bus.out_data  <= to_hex(bus.rd_data[DATA_W-1 -: 4]);
          state         <= EMIT;
        end
        EMIT: begin
          if (bus.out_ready) begin
            shift <= shift_next;
            count <= count + 1'b1;
            if (count == LAST_NIB) begin
              bus.out_data <= 8'h0A;
              state        <= EOL;
            end else begin
              bus.out_data <= to_hex(shift_next[DATA_W-1 -: 4]);
            end
          end
        end
        EOL: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (addr == end_q) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              addr        <= next_addr;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= next_addr;
              state       <= FETCH;
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state         <= IDLE;
          bus.rd_en     <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_hexdump.sv
// tb_mem_hexdump
// Directed bench for mem_hexdump (DATA_W=16, ADDR_W=2). A small memory model
// answers reads one cycle after rd_en; expected bytes and read addresses are
// pushed to queues when a dump is requested and popped as the DUT produces
// them. Outputs are sampled on the falling clock edge.
module tb_mem_hexdump;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;

  logic clk;
  logic rst;

  mem_hexdump_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_hexdump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image and read model: data appears the cycle after the strobe.
  logic [DATA_W-1:0] mem [4];
  initial begin
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    mem[2] = 16'h9abc;
    mem[3] = 16'hdef0;
  end

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]        exp_bytes [$];
  logic [ADDR_W-1:0] exp_addrs [$];
  logic [7:0]        rx_q      [$];

  int   cyc;
  int   first_valid_cyc;
  int   done_cyc;
  int   rd_count;
  int   stall_from;
  int   stall_len;
  logic prev_stall;

  string hex_digits = "0123456789abcdef";
  string golden     = "1234\n5678\n9abc\ndef0\n";

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: sample at the falling edge, score, then advance.
  task automatic tick();
    logic [7:0]        eb;
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    if (prev_stall) begin
      checkOutput("hold valid", 32'(bus.out_valid), 32'd1);
      eb = (exp_bytes.size() > 0) ? exp_bytes[0] : 8'hxx;
      checkOutput("hold data", 32'(bus.out_data), 32'(eb));
    end
    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.out_valid && bus.out_ready) begin
      checkOutput("byte expected", 32'(exp_bytes.size() > 0), 32'd1);
      if (exp_bytes.size() > 0) begin
        eb = exp_bytes.pop_front();
        checkOutput("out_data", 32'(bus.out_data), 32'(eb));
      end
      rx_q.push_back(bus.out_data);
    end
    if (bus.rd_en) begin
      rd_count++;
      checkOutput("read expected", 32'(exp_addrs.size() > 0), 32'd1);
      if (exp_addrs.size() > 0) begin
        ea = exp_addrs.pop_front();
        checkOutput("rd_addr", 32'(bus.rd_addr), 32'(ea));
      end
    end
    if (bus.done && done_cyc < 0) done_cyc = cyc;
    prev_stall = bus.out_valid && !bus.out_ready;
    @(posedge clk);
    #1;
    cyc++;
    bus.out_ready = !(stall_from >= 0 && cyc >= stall_from && cyc < stall_from + stall_len);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Queue the expected text for a dump, then pulse start for one edge.
  task automatic applyStimulus(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] w;
    a = s;
    forever begin
      exp_addrs.push_back(a);
      w = mem[a];
      for (int k = DATA_W / 4 - 1; k >= 0; k--) exp_bytes.push_back(hex_digits[w[k*4 +: 4]]);
      exp_bytes.push_back(8'h0A);
      if (a == e) break;
      a = (s > e) ? a - 1'b1 : a + 1'b1;
    end
    rx_q.delete();
    bus.start      = 1'b1;
    bus.start_addr = s;
    bus.end_addr   = e;
    tick();
    bus.start       = 1'b0;
    cyc             = 0;
    first_valid_cyc = -1;
    done_cyc        = -1;
    rd_count        = 0;
  endtask

  // Run to the done pulse (bounded), then check timing and the idle return.
  task automatic runDump(input string tag, input int exp_done, input int exp_reads);
    while (done_cyc < 0 && cyc < 200) tick();
    checkOutput({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    checkOutput({tag, " first valid"}, 32'(first_valid_cyc), 32'd2);
    checkOutput({tag, " reads"}, 32'(rd_count), 32'(exp_reads));
    checkOutput({tag, " bytes left"}, 32'(exp_bytes.size()), 32'd0);
    tick();
    checkOutput({tag, " busy after"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " done after"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.end_addr   = '0;
    bus.out_ready  = 1'b1;
    bus.rd_data    = '0;
    cyc = 0; first_valid_cyc = -1; done_cyc = -1; rd_count = 0;
    stall_from = -1; stall_len = 0; prev_stall = 1'b0;

    #12;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_data", 32'(bus.out_data), 32'h00);
    checkOutput("reset rd_en", 32'(bus.rd_en), 32'd0);
    checkOutput("reset rd_addr", 32'(bus.rd_addr), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] ascending 0->3");
    applyStimulus(2'd0, 2'd3);
    runDump("asc", 28, 4);
    checkOutput("asc length", 32'(rx_q.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'h00;
      checkOutput("asc text", 32'(got), 32'(golden[i]));
    end

    $display("[TB] descending 3->1");
    applyStimulus(2'd3, 2'd1);
    runDump("desc", 21, 3);

    $display("[TB] single word 2->2");
    applyStimulus(2'd2, 2'd2);
    runDump("single", 7, 1);

    $display("[TB] backpressure on second character");
    stall_from = 3;
    stall_len  = 3;
    applyStimulus(2'd0, 2'd3);
    runDump("stall", 31, 4);
    stall_from = -1;

    $display("[TB] start ignored while busy");
    applyStimulus(2'd0, 2'd3);
    runCycles(5);
    bus.start      = 1'b1;
    bus.start_addr = 2'd3;
    bus.end_addr   = 2'd3;
    runCycles(1);
    bus.start = 1'b0;
    runDump("busy start", 28, 4);

    $display("[TB] reset during word 1");
    applyStimulus(2'd0, 2'd3);
    runCycles(10);
    checkOutput("pre-reset valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async rst busy", 32'(bus.busy), 32'd0);
    checkOutput("async rst rd_en", 32'(bus.rd_en), 32'd0);
    exp_bytes.delete();
    exp_addrs.delete();
    prev_stall = 1'b0;
    #1;
    rst = 1'b0;
    applyStimulus(2'd0, 2'd0);
    runDump("after reset", 7, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_hexdump.md
MEM_HEXDUMP -- requirements
Module: mem_hexdump

Interface
REQ-001 Parameter DATA_W, default 16, word width; SHALL be a multiple of 4; NCHR = DATA_W/4 hex characters per word.
REQ-002 Parameter ADDR_W, default 2, memory address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  first word address; latched when start is accepted.
REQ-007 end_addr  input  ADDR_W  last word address; latched when start is accepted.
REQ-008 rd_en  output  1  memory read strobe.
REQ-009 rd_addr  output  ADDR_W  memory read address.
REQ-010 rd_data  input  DATA_W  memory read data; valid exactly one cycle after the rd_en cycle.
REQ-011 out_valid  output  1  out_data holds a valid ASCII byte.
REQ-012 out_data  output  8  ASCII character.
REQ-013 out_ready  input  1  sink accepts byte when out_valid and out_ready are high on the same edge.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse when the last newline has been accepted.

Function
REQ-016 Block SHALL emit memory words as hex text readable by $readmemh: per word, NCHR characters, MS nibble first, then 0x0A.
REQ-017 Nibble encoding SHALL be 0-9 -> 0x30-0x39 and 10-15 -> 0x61-0x66 (lowercase).
REQ-018 Direction: start_addr <= end_addr SHALL walk ascending (+1); start_addr > end_addr SHALL walk descending (-1); both endpoints are included.
REQ-019 States SHALL be IDLE, FETCH, WAIT, EMIT, EOL, DONE.
REQ-020 IDLE: start=1 -> latch addresses, addr=start_addr, go to FETCH; otherwise stay.
REQ-021 FETCH: rd_en=1, rd_addr=addr for exactly one cycle -> WAIT.
REQ-022 WAIT: capture rd_data into shift register, nibble count=0 -> EMIT.
REQ-023 EMIT: out_valid=1, out_data=ASCII of top nibble; on handshake, shift left 4 and increment count; the handshake on nibble NCHR-1 -> EOL.
REQ-024 EOL: out_valid=1, out_data=0x0A; on handshake, if addr==end_addr -> DONE, else step addr -> FETCH.
REQ-025 DONE: done=1 for one cycle -> IDLE.
REQ-026 With out_valid high and out_ready low, out_valid and out_data SHALL hold unchanged.
REQ-027 out_valid SHALL be low in IDLE, FETCH, WAIT and DONE.
REQ-028 rd_en SHALL be high only in FETCH.
REQ-029 Latency: the first out_valid SHALL occur 3 cycles after the start edge (cycles: FETCH, WAIT, then EMIT).
REQ-030 Throughput with out_ready held high SHALL be NCHR+3 cycles per word.
REQ-031 start while busy SHALL be ignored, with no effect on the current dump.
REQ-032 Address stepping SHALL be modulo 2^ADDR_W. Because the endpoints are checked per REQ-018, wrap never occurs in a legal dump.

Reset
REQ-033 rst high SHALL force IDLE asynchronously, from any state including mid-word.
REQ-034 Reset values: out_valid=0, out_data=0x00, rd_en=0, rd_addr=0, busy=0, done=0; address, shift register and nibble count = 0.
REQ-035 After rst is released, the block SHALL accept start on the first rising edge.

Verification
REQ-036 The bench SHALL use DATA_W=16 and ADDR_W=2, with memory {0:1234, 1:5678, 2:9abc, 3:def0}.
REQ-037 Ascending dump, start 0->3, out_ready=1 -> byte stream "1234\n5678\n9abc\ndef0\n" (20 bytes, 28 cycles after start), then done pulse, busy low.
REQ-038 Descending dump, start 3->1 -> "def0\n9abc\n5678\n"; rd_addr sequence 3,2,1.
REQ-039 Single-word dump, start 2->2 -> "9abc\n", exactly one rd_en, then done.
REQ-040 Backpressure: out_ready low 3 cycles while the 2nd character '2' (0x32) is presented -> out_data stays 0x32 and out_valid stays 1; the stream is otherwise unchanged.
REQ-041 Reset mid-dump, asserted during EMIT of word 1 -> out_valid, busy, rd_en go 0 immediately; a new start 0->0 then yields "1234\n".
REQ-042 start pulsed during an active 0->3 dump with start_addr=3, end_addr=3 -> it is ignored; the output is identical to REQ-037.
